csr_trap_ctrl: RTL
==================

Name: csr_trap_ctrl

Overview:
- Commit-stage controller that sequences every access to the CSR register file from the write-back stage.
- Arbitrates between external interrupt, synchronous exception, ERTN and CSR-write instructions, and drives the CSR file's write, trap and ertn strobes.
- After a trap, ertn or state-changing CSR write, it runs a flush/redirect sequence toward the fetch stage.
- Sits between the WB pipeline register and the CSR register file; the IF stage consumes its redirect.

Parameters:
- FLUSH_CYCLES, 1, cycles flush_pipe stays high after a flushing commit; legal range 1..15.
- ECODE_INT, 6'h00, ecode reported for interrupts.
- PC_STEP, 4, refetch offset added to ws_pc after a state-changing CSR write.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- ws_valid  in  1  WB holds a valid instruction
- ws_pc  in  32  WB instruction PC
- ws_ex  in  1  WB instruction carries a synchronous exception
- ws_ecode  in  6  exception code
- ws_esubcode  in  9  exception subcode
- ws_vaddr  in  32  faulting data address
- ws_ertn  in  1  WB instruction is ERTN
- ws_csr_we  in  1  WB instruction writes a CSR
- ws_csr_num  in  14  target CSR number
- ws_csr_wmask  in  32  write mask
- ws_csr_wdata  in  32  write data
- has_int  in  1  pending, enabled interrupt (level, from CSR file)
- ex_entry  in  32  trap entry address
- csr_era  in  32  current ERA value
- ws_ready  out  1  WB may commit this cycle
- csr_we  out  1  CSR write strobe
- csr_waddr  out  14  CSR write address
- csr_wmask  out  32  CSR write mask
- csr_wdata  out  32  CSR write data
- wb_ex  out  1  trap commit strobe
- wb_ecode  out  6  trap ecode
- wb_esubcode  out  9  trap subcode
- wb_pc  out  32  trap PC
- wb_vaddr  out  32  trap bad address
- ertn_flush  out  1  ERTN commit strobe
- flush_pipe  out  1  kill all younger instructions
- redirect_valid  out  1  one-cycle fetch redirect
- redirect_pc  out  32  redirect target

Behaviour:
- States: IDLE, FLUSH, REDIRECT. Reset: IDLE, flush counter 0, target register 0.
- All outputs are 0 on the reset cycle, except ws_ready = 1 in IDLE.
- ws_ready = 1 only in IDLE. A commit requires ws_valid && state==IDLE.
- Commit strobes (csr_we, wb_ex, ertn_flush) are combinational in the commit cycle so the CSR file samples them at the next posedge. At most one strobe is high per cycle.
- Priority in the commit cycle, highest first:
  - Interrupt (has_int): wb_ex=1, wb_ecode=ECODE_INT, wb_esubcode=0, wb_pc=ws_pc, wb_vaddr=ws_vaddr.
  - ws_ex: wb_ex=1 with ws_ecode / ws_esubcode / ws_pc / ws_vaddr.
  - ws_ertn: ertn_flush=1.
  - ws_csr_we: csr_we=1, waddr/wmask/wdata passed through.
- A trap suppresses csr_we and ertn_flush of the same instruction. An interrupt overrides ws_ex, ertn and CSR write.
- wb_* data outputs are 0 whenever wb_ex=0. csr_w* data outputs are 0 whenever csr_we=0.
- Flushing commits and captured redirect targets:
  - trap: ex_entry
  - ertn: csr_era, sampled at commit before the CSR update
  - CSR write to CRMD(0x0), ECFG(0x4), ESTAT(0x5) or TICLR(0x44): ws_pc+PC_STEP, mod 2^32
- Other CSR writes commit with no flush; the FSM stays in IDLE.
- On a flushing commit: go to FLUSH and load counter = FLUSH_CYCLES.
- FLUSH: flush_pipe=1, ws_ready=0, all commit strobes forced 0 (has_int and ws_valid ignored). Counter decrements each cycle; at 1, go to REDIRECT.
- REDIRECT: flush_pipe=1, redirect_valid=1, redirect_pc=captured target, ws_ready=0; next state IDLE.
- redirect_pc is 0 whenever redirect_valid=0.
- has_int held across FLUSH/REDIRECT is taken on the first valid WB instruction after returning to IDLE.
- Reset in any state takes effect on the next posedge: IDLE, all strobes and flush low, pending sequence discarded.

Test Plan:
- IDLE, ws_valid, ws_csr_we, num=0x30, wdata=0x1234, mask=0xFFFFFFFF -> csr_we=1 one cycle, csr_waddr=0x30, no flush_pipe, ws_ready stays 1.
- ws_ex, ecode=0x9, vaddr=0x1003, pc=0x1C000100, ex_entry=0x1C008000, FLUSH_CYCLES=1 -> wb_ex=1 cycle 0; flush_pipe cycles 1–2; redirect_valid cycle 2 with pc 0x1C008000; ws_ready=1 cycle 3.
- has_int=1 together with ws_csr_we to SAVE0 -> wb_ex=1, wb_ecode=0, csr_we=0, redirect to ex_entry.
- ws_ertn, csr_era=0x1C000200 -> ertn_flush=1 one cycle, later redirect_pc=0x1C000200; ws_valid presented during FLUSH produces no strobe.
- CSR write to CRMD at pc=0xFFFFFFFC -> csr_we=1, redirect_pc=0x00000000 (wrap-around).
- Reset asserted in FLUSH with FLUSH_CYCLES=4 -> next cycle IDLE, flush_pipe=0, redirect_valid never asserted.

Source files
------------

// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: commit-stage sequencer for CSR writes, traps and ERTN,
// with a flush/redirect sequence toward fetch after state-changing commits.
module csr_trap_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter logic [5:0]  ECODE_INT    = 6'h00,
  parameter logic [31:0] PC_STEP      = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ws_valid,
  input  logic [31:0] ws_pc,
  input  logic        ws_ex,
  input  logic [5:0]  ws_ecode,
  input  logic [8:0]  ws_esubcode,
  input  logic [31:0] ws_vaddr,
  input  logic        ws_ertn,
  input  logic        ws_csr_we,
  input  logic [13:0] ws_csr_num,
  input  logic [31:0] ws_csr_wmask,
  input  logic [31:0] ws_csr_wdata,
  input  logic        has_int,
  input  logic [31:0] ex_entry,
  input  logic [31:0] csr_era,
  output logic        ws_ready,
  output logic        csr_we,
  output logic [13:0] csr_waddr,
  output logic [31:0] csr_wmask,
  output logic [31:0] csr_wdata,
  output logic        wb_ex,
  output logic [5:0]  wb_ecode,
  output logic [8:0]  wb_esubcode,
  output logic [31:0] wb_pc,
  output logic [31:0] wb_vaddr,
  output logic        ertn_flush,
  output logic        flush_pipe,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned ST_W  = 2;

  localparam logic [ST_W-1:0] S_IDLE     = 2'd0;
  localparam logic [ST_W-1:0] S_FLUSH    = 2'd1;
  localparam logic [ST_W-1:0] S_REDIRECT = 2'd2;

  // CSRs whose update changes machine state seen by younger instructions
  localparam logic [13:0] CSR_CRMD  = 14'h0000;
  localparam logic [13:0] CSR_ECFG  = 14'h0004;
  localparam logic [13:0] CSR_ESTAT = 14'h0005;
  localparam logic [13:0] CSR_TICLR = 14'h0044;

  logic [ST_W-1:0]  state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      target, target_nx;
  logic             csr_flush_num;

  assign csr_flush_num = (ws_csr_num == CSR_CRMD)  || (ws_csr_num == CSR_ECFG) ||
                         (ws_csr_num == CSR_ESTAT) || (ws_csr_num == CSR_TICLR);

  // State, flush counter and captured redirect target
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      cnt    <= '0;
      target <= '0;
    end else begin
      state  <= state_nx;
      cnt    <= cnt_nx;
      target <= target_nx;
    end
  end

  // Commit arbitration (interrupt > exception > ertn > csr write) and sequencing
  always_comb begin
    state_nx       = state;
    cnt_nx         = cnt;
    target_nx      = target;
    ws_ready       = 1'b0;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wmask      = '0;
    csr_wdata      = '0;
    wb_ex          = 1'b0;
    wb_ecode       = '0;
    wb_esubcode    = '0;
    wb_pc          = '0;
    wb_vaddr       = '0;
    ertn_flush     = 1'b0;
    flush_pipe     = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state)
      S_IDLE: begin
        ws_ready = 1'b1;
        if (ws_valid && !reset) begin
          if (has_int || ws_ex) begin
            wb_ex       = 1'b1;
            wb_ecode    = has_int ? ECODE_INT : ws_ecode;
            wb_esubcode = has_int ? 9'd0 : ws_esubcode;
            wb_pc       = ws_pc;
            wb_vaddr    = ws_vaddr;
            state_nx    = S_FLUSH;
            cnt_nx      = CNT_W'(FLUSH_CYCLES);
            target_nx   = ex_entry;
          end else if (ws_ertn) begin
            ertn_flush = 1'b1;
            state_nx   = S_FLUSH;
            cnt_nx     = CNT_W'(FLUSH_CYCLES);
            target_nx  = csr_era;
          end else if (ws_csr_we) begin
            csr_we    = 1'b1;
            csr_waddr = ws_csr_num;
            csr_wmask = ws_csr_wmask;
            csr_wdata = ws_csr_wdata;
            if (csr_flush_num) begin
              state_nx  = S_FLUSH;
              cnt_nx    = CNT_W'(FLUSH_CYCLES);
              target_nx = ws_pc + PC_STEP;
            end
          end
        end
      end
      S_FLUSH: begin
        flush_pipe = !reset;
        if (cnt <= CNT_W'(1)) begin
          state_nx = S_REDIRECT;
          cnt_nx   = '0;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      S_REDIRECT: begin
        flush_pipe     = !reset;
        redirect_valid = !reset;
        redirect_pc    = reset ? 32'd0 : target;
        state_nx       = S_IDLE;
      end
      default: begin
        state_nx = S_IDLE;
      end
    endcase
  end

endmodule
